// File: rtl/alu_5bit.sv
// alu_5bit: registered 5-bit ALU with two operations.
//   OP=0 : NOT A
//   OP=1 : rotate A left by (B mod 5)
// Result and CF/SF/ZF flags are registered, so each result appears one cycle
// after its operands are sampled. Reset is synchronous and clears all outputs.
module alu_5bit (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] A,
  input  logic [4:0] B,
  input  logic       OP,
  output logic [4:0] result,
  output logic       CF,
  output logic       SF,
  output logic       ZF
);

  localparam logic OP_NOT = 1'b0;
  localparam logic OP_ROL = 1'b1;

  // A duplicated end to end. A 5-bit window taken from this is A rotated
  // left by the window's offset from the top.
  logic [9:0] a_dbl;
  assign a_dbl = {A, A};

  // All five possible rotations of A; the effective shift amount selects one.
  logic [4:0] rot [5];

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_rot
      assign rot[gi] = a_dbl[9-gi -: 5];
    end
  endgenerate

  // Effective rotate amount; rotating a 5-bit word by 5 is the identity.
  logic [4:0] b_mod;
  logic [2:0] rot_amt;
  assign b_mod   = B % 5'd5;
  assign rot_amt = b_mod[2:0];

  logic [4:0] result_d, result_q;
  logic       cf_d, cf_q;
  logic       sf_d, sf_q;
  logic       zf_d, zf_q;

  // Combinational datapath: pick the operation, then derive the flags from
  // the selected result.
  always_comb begin
    result_d = 5'b00000;
    cf_d     = 1'b0;
    unique case (OP)
      OP_NOT: begin
        result_d = ~A;
        cf_d     = 1'b0;
      end
      OP_ROL: begin
        result_d = rot[rot_amt];
        // The last bit leaving bit 4 wraps into bit 0. No rotation means no
        // bit left the word, so there is no carry.
        cf_d     = (rot_amt != 3'd0) ? result_d[0] : 1'b0;
      end
      default: begin
        result_d = 5'b00000;
        cf_d     = 1'b0;
      end
    endcase
    sf_d = result_d[4];
    zf_d = (result_d == 5'b00000);
  end

  // Output registers. ZF is cleared on reset because no operation has
  // completed yet, even though result reads as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= 5'b00000;
      cf_q     <= 1'b0;
      sf_q     <= 1'b0;
      zf_q     <= 1'b0;
    end else begin
      result_q <= result_d;
      cf_q     <= cf_d;
      sf_q     <= sf_d;
      zf_q     <= zf_d;
    end
  end

  assign result = result_q;
  assign CF     = cf_q;
  assign SF     = sf_q;
  assign ZF     = zf_q;

endmodule

// File: tb/tb_alu_5bit.sv
// Self-checking bench for alu_5bit. Each driven vector pushes its expected
// {result, CF, SF, ZF} into a scoreboard queue; the entry is popped and
// compared one clock later when the registered output is valid.
module tb_alu_5bit;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] A;
  logic [4:0] B;
  logic       OP;
  logic [4:0] result;
  logic       CF;
  logic       SF;
  logic       ZF;

  int checks = 0;
  int passes = 0;

  logic [7:0] exp_q[$];

  alu_5bit dut (
    .clk    (clk),
    .rst    (rst),
    .A      (A),
    .B      (B),
    .OP     (OP),
    .result (result),
    .CF     (CF),
    .SF     (SF),
    .ZF     (ZF)
  );

  always #5 clk = ~clk;

  // Reference model: rotation done one bit at a time, carry is the last bit
  // pushed out of bit 4.
  function automatic logic [7:0] model(input logic [4:0] a, input logic [4:0] b,
                                       input logic op);
    logic [4:0] r;
    logic       c;
    int         n;
    if (op == 1'b0) begin
      r = ~a;
      c = 1'b0;
    end else begin
      n = int'(b) % 5;
      r = a;
      c = 1'b0;
      for (int i = 0; i < n; i++) begin
        c = r[4];
        r = {r[3:0], r[4]};
      end
    end
    return {r, c, r[4], (r == 5'b00000)};
  endfunction

  // Apply one vector for one clock and record what it should produce.
  task automatic drive(input logic rst_v, input logic [4:0] a, input logic [4:0] b,
                       input logic op, input logic [7:0] expv);
    rst = rst_v;
    A   = a;
    B   = b;
    OP  = op;
    exp_q.push_back(expv);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] e;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 5'($urandom), 5'($urandom), 1'($urandom), 8'h00);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
      checks++;
      if ({result, CF, SF, ZF} !== e)
        $display("FAIL reset_%0d: got %b, required %b", i, {result, CF, SF, ZF}, e);
      else passes++;
    end
    drive(1'b0, 5'b00101, 5'b00000, 1'b0, {5'b11010, 1'b0, 1'b1, 1'b0});
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
    checks++;
    if ({result, CF, SF, ZF} !== e)
      $display("FAIL reset_release: got %b, required %b", {result, CF, SF, ZF}, e);
    else passes++;
    $display("test_reset done");
  endtask

  task automatic test_not();
    logic [4:0] a_tab [3] = '{5'b00101, 5'b00000, 5'b11111};
    logic [7:0] x_tab [3] = '{{5'b11010, 3'b010}, {5'b11111, 3'b010}, {5'b00000, 3'b001}};
    logic [7:0] e;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, a_tab[i], 5'($urandom), 1'b0, x_tab[i]);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
      checks++;
      if ({result, CF, SF, ZF} !== e)
        $display("FAIL not_%0d A=%b: got %b, required %b", i, a_tab[i], {result, CF, SF, ZF}, e);
      else passes++;
      $display("NOT A=%b -> %b", a_tab[i], {result, CF, SF, ZF});
    end
  endtask

  task automatic test_rol();
    logic [4:0] a_tab [7] = '{5'b10000, 5'b10110, 5'b01011, 5'b01011,
                              5'b00001, 5'b10000, 5'b00000};
    logic [4:0] b_tab [7] = '{5'd1, 5'd3, 5'd5, 5'd7, 5'd31, 5'd0, 5'd3};
    logic [7:0] x_tab [7] = '{{5'b00001, 3'b100}, {5'b10101, 3'b110},
                              {5'b01011, 3'b000}, {5'b01101, 3'b100},
                              {5'b00010, 3'b000}, {5'b10000, 3'b010},
                              {5'b00000, 3'b001}};
    logic [7:0] e;
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, a_tab[i], b_tab[i], 1'b1, x_tab[i]);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
      checks++;
      if ({result, CF, SF, ZF} !== e)
        $display("FAIL rol_%0d A=%b B=%0d: got %b, required %b",
                 i, a_tab[i], b_tab[i], {result, CF, SF, ZF}, e);
      else passes++;
      $display("ROL A=%b B=%0d -> %b", a_tab[i], b_tab[i], {result, CF, SF, ZF});
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] a, b;
    logic [7:0] e;
    for (int i = 0; i < 40; i++) begin
      a = 5'($urandom);
      b = 5'($urandom);
      drive(1'b0, a, b, 1'(i), model(a, b, 1'(i)));
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
      checks++;
      if ({result, CF, SF, ZF} !== e)
        $display("FAIL b2b_%0d OP=%0d A=%b B=%0d: got %b, required %b",
                 i, i % 2, a, b, {result, CF, SF, ZF}, e);
      else passes++;
      $display("b2b OP=%0d A=%b B=%0d -> %b", i % 2, a, b, {result, CF, SF, ZF});
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] e;
    logic [4:0] a_tab [4] = '{5'b11111, 5'b01010, 5'b00110, 5'b10001};
    logic [4:0] b_tab [4] = '{5'd2, 5'd9, 5'd1, 5'd4};
    logic       r_tab [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      drive(r_tab[i], a_tab[i], b_tab[i], 1'b1,
            r_tab[i] ? 8'h00 : model(a_tab[i], b_tab[i], 1'b1));
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
      checks++;
      if ({result, CF, SF, ZF} !== e)
        $display("FAIL midrst_%0d rst=%0d: got %b, required %b",
                 i, r_tab[i], {result, CF, SF, ZF}, e);
      else passes++;
      $display("midrst rst=%0d A=%b B=%0d -> %b", r_tab[i], a_tab[i], b_tab[i],
               {result, CF, SF, ZF});
    end
  endtask

  initial begin
    rst = 1'b1;
    A   = 5'b0;
    B   = 5'b0;
    OP  = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_not();
    test_rol();
    test_back_to_back();
    test_mid_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
